// File: rtl/imem_loader.sv
// imem_loader: instruction memory with a streaming valid/ready program-load
// port and a boot sequencer that holds the MIPS core in reset until a load
// completes. The core fetches over a combinational PC read port.
// Optional feature macro: IMEM_BOUNDS_CHECK_EN enables fetch range/alignment
// faults and load overflow detection. When it is undefined, the fetch index
// and the load pointer both wrap.
module imem_loader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic [ADDR_W-1:0]        load_base,
  input  logic                     load_valid,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic [$clog2(DEPTH):0]   load_count,
  output logic                     load_err,
  output logic                     busy,
  output logic                     core_reset,
  input  logic [ADDR_W-1:0]        pc,
  output logic [DATA_W-1:0]        instruction,
  output logic                     pc_fault
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              start_s;
  logic              beat_s;
  logic              full_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic [DATA_W-1:0] rd_word_s;

  // A new load may only begin from IDLE or RUN; starts during LOAD/RELEASE are dropped.
  assign start_s  = load_start && ((state_q == S_IDLE) || (state_q == S_RUN));
  assign beat_s   = load_valid && (state_q == S_LOAD);
  assign full_s   = (count_q == CNT_FULL);
  assign rd_idx_s = pc[2 +: IDX_W];
  assign rd_word_s = mem[rd_idx_s];

`ifdef IMEM_BOUNDS_CHECK_EN
  logic oob_s;
  // Fetch beyond the array or a non-word-aligned PC is a fault.
  assign oob_s   = (|pc[ADDR_W-1:IDX_W+2]) || (pc[1:0] != 2'b00);
  // Beats past the DEPTH-th word of a load are dropped rather than wrapped.
  assign wr_en_s = beat_s && !full_s;
  logic unused_s;
  assign unused_s = ^load_base[ADDR_W-1:IDX_W+2];
`else
  assign wr_en_s = beat_s;
  logic unused_s;
  assign unused_s = ^{load_base[ADDR_W-1:IDX_W+2], pc[ADDR_W-1:IDX_W+2], pc[1:0]};
`endif

  // FSM state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: IDLE -> LOAD -> RELEASE -> RUN, reload from RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load_start) state_d = S_LOAD;
        else            state_d = S_IDLE;
      end
      S_LOAD: begin
        if (beat_s && load_last) state_d = S_RELEASE;
        else                     state_d = S_LOAD;
      end
      S_RELEASE: state_d = S_RUN;
      S_RUN: begin
        if (load_start) state_d = S_LOAD;
        else            state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Load datapath next-state: word pointer, accepted-word count and sticky error.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    if (start_s) begin
      ptr_d   = load_base[2 +: IDX_W];
      count_d = {CNT_W{1'b0}};
      err_d   = (load_base[1:0] != 2'b00);
    end else if (beat_s) begin
      if (wr_en_s) ptr_d = ptr_q + IDX_W'(1);
      else         ptr_d = ptr_q;
      if (full_s)  count_d = count_q;
      else         count_d = count_q + CNT_W'(1);
`ifdef IMEM_BOUNDS_CHECK_EN
      if (full_s)  err_d = 1'b1;
      else         err_d = err_q;
`else
      err_d = err_q;
`endif
    end else begin
      ptr_d   = ptr_q;
      count_d = count_q;
      err_d   = err_q;
    end
  end

  // Load datapath registers; reset clears count and error.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= {IDX_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem[ptr_q] <= load_data;
    end
  end

  // Output decode: handshake/boot controls from state, combinational fetch in RUN.
  always_comb begin
    load_ready  = 1'b0;
    busy        = 1'b0;
    core_reset  = 1'b1;
    instruction = {DATA_W{1'b0}};
    pc_fault    = 1'b0;
    case (state_q)
      S_IDLE: begin
        core_reset = 1'b1;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
      end
      S_RELEASE: begin
        busy = 1'b1;
      end
      S_RUN: begin
        core_reset = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
        if (oob_s) begin
          pc_fault    = 1'b1;
          instruction = {DATA_W{1'b0}};
        end else begin
          pc_fault    = 1'b0;
          instruction = rd_word_s;
        end
`else
        instruction = rd_word_s;
`endif
      end
      default: begin
        core_reset = 1'b1;
      end
    endcase
  end

  assign load_count = count_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (DEPTH=64). Expectations that
// depend on IMEM_BOUNDS_CHECK_EN follow the same macro.
module tb_imem_loader;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              reset;
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic [6:0]        load_count;
  logic              load_err;
  logic              busy;
  logic              core_reset;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instruction;
  logic              pc_fault;

  int n_assert;
  int n_fail;

  logic [31:0] prog [10] = '{32'h2128000A, 32'h21290002, 32'h01095000, 32'h01084000,
                             32'h010A5801, 32'hAD0B0004, 32'h4D0C0004, 32'h116C0001,
                             32'h016C5801, 32'h016C5800};

  imem_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_base(load_base),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_count(load_count), .load_err(load_err),
    .busy(busy), .core_reset(core_reset), .pc(pc), .instruction(instruction),
    .pc_fault(pc_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [31:0] base);
    load_start = 1'b1;
    load_base  = base;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 32'hDEADBEEF;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    chk(tag, {32'h0, instruction}, {32'h0, exp});
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    load_start = 1'b0;
    load_base  = 32'h0;
    load_valid = 1'b0;
    load_data  = 32'h0;
    load_last  = 1'b0;
    pc         = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst_ready", {63'h0, load_ready}, 64'h0);
    chk("rst_count", {57'h0, load_count}, 64'h0);
    chk("rst_err", {63'h0, load_err}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_core_reset", {63'h0, core_reset}, 64'h1);
    chk("rst_instr", {32'h0, instruction}, 64'h0);
    chk("rst_pc_fault", {63'h0, pc_fault}, 64'h0);
    reset = 1'b0;
    tick();

    // Load 10 words back-to-back from base 0
    start_load(32'h0);
    chk("t1_ready_up", {63'h0, load_ready}, 64'h1);
    chk("t1_busy", {63'h0, busy}, 64'h1);
    for (int i = 0; i < 10; i++) begin
      send(prog[i], (i == 9));
      chk("t1_count_step", {57'h0, load_count}, 64'(i + 1));
    end
    pc = 32'h8;
    #1;
    chk("t1_rel_core_reset", {63'h0, core_reset}, 64'h1);
    chk("t1_rel_ready_down", {63'h0, load_ready}, 64'h0);
    chk("t1_rel_busy", {63'h0, busy}, 64'h1);
    chk("t1_rel_instr_nop", {32'h0, instruction}, 64'h0);
    tick();
    chk("t1_run_core_reset", {63'h0, core_reset}, 64'h0);
    chk("t1_run_busy", {63'h0, busy}, 64'h0);
    chk("t1_count", {57'h0, load_count}, 64'd10);
    chk("t1_err", {63'h0, load_err}, 64'h0);
    fetch("t1_pc8", 32'h8, 32'h01095000);
    fetch("t1_pc36", 32'd36, 32'h016C5800);
    tick();
    chk("t1_count_hold", {57'h0, load_count}, 64'd10);

    // Reload from RUN with load_valid toggled every other cycle
    start_load(32'h0);
    chk("t2_count_clear", {57'h0, load_count}, 64'h0);
    for (int i = 0; i < 10; i++) begin
      send(prog[i], (i == 9));
      if (i < 9) tick();
    end
    tick();
    chk("t2_core_reset", {63'h0, core_reset}, 64'h0);
    chk("t2_count", {57'h0, load_count}, 64'd10);
    chk("t2_err", {63'h0, load_err}, 64'h0);
    for (int i = 0; i < 10; i++) begin
      fetch("t2_mem", 32'(i * 4), prog[i]);
    end

    // Misaligned base 0x6: error set, word lands at index 1
    start_load(32'h6);
    chk("t4_err_set", {63'h0, load_err}, 64'h1);
    send(32'hAAAA0001, 1'b1);
    tick();
    chk("t4_count", {57'h0, load_count}, 64'd1);
    chk("t4_err_hold", {63'h0, load_err}, 64'h1);
    fetch("t4_word1", 32'h4, 32'hAAAA0001);
    fetch("t4_word0", 32'h0, 32'h2128000A);
    fetch("t4_word2", 32'h8, 32'h01095000);

    // Overflow: DEPTH+1 beats from base 0
    start_load(32'h0);
    chk("t3_err_cleared", {63'h0, load_err}, 64'h0);
    for (int i = 0; i <= DEPTH; i++) begin
      send(32'h50000000 + 32'(i), (i == DEPTH));
    end
    tick();
    chk("t3_count_sat", {57'h0, load_count}, 64'd64);
    fetch("t3_last_word", 32'd252, 32'h5000003F);
`ifdef IMEM_BOUNDS_CHECK_EN
    chk("t3_err", {63'h0, load_err}, 64'h1);
    fetch("t3_word0", 32'h0, 32'h50000000);
`else
    chk("t3_err", {63'h0, load_err}, 64'h0);
    fetch("t3_word0", 32'h0, 32'h50000040);
`endif

    // Reset after 3 of 10 beats
    start_load(32'h0);
    for (int i = 0; i < 3; i++) begin
      send(32'h70000000 + 32'(i), 1'b0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_ready", {63'h0, load_ready}, 64'h0);
    chk("t5_busy", {63'h0, busy}, 64'h0);
    chk("t5_core_reset", {63'h0, core_reset}, 64'h1);
    chk("t5_instr", {32'h0, instruction}, 64'h0);
    chk("t5_count", {57'h0, load_count}, 64'h0);
    start_load(32'h10);
    send(32'h7000AAAA, 1'b0);
    send(32'h7000BBBB, 1'b1);
    tick();
    chk("t5_core_reset_run", {63'h0, core_reset}, 64'h0);
    chk("t5_count2", {57'h0, load_count}, 64'd2);
    fetch("t5_keep0", 32'h0, 32'h70000000);
    fetch("t5_keep1", 32'h4, 32'h70000001);
    fetch("t5_keep2", 32'h8, 32'h70000002);
    fetch("t5_new4", 32'h10, 32'h7000AAAA);
    fetch("t5_new5", 32'h14, 32'h7000BBBB);
    fetch("t5_old3", 32'hC, 32'h50000003);

    // Fetch bounds and alignment in RUN
`ifdef IMEM_BOUNDS_CHECK_EN
    fetch("t6_pc256_instr", 32'd256, 32'h0);
    chk("t6_pc256_fault", {63'h0, pc_fault}, 64'h1);
    fetch("t6_pc2_instr", 32'h2, 32'h0);
    chk("t6_pc2_fault", {63'h0, pc_fault}, 64'h1);
`else
    fetch("t6_pc256_instr", 32'd256, 32'h70000000);
    chk("t6_pc256_fault", {63'h0, pc_fault}, 64'h0);
    fetch("t6_pc2_instr", 32'h2, 32'h70000000);
    chk("t6_pc2_fault", {63'h0, pc_fault}, 64'h0);
`endif
    fetch("t6_pc4_instr", 32'h4, 32'h70000001);
    chk("t6_pc4_fault", {63'h0, pc_fault}, 64'h0);

    // Simultaneous reset and load_start: reset wins
    reset      = 1'b1;
    load_start = 1'b1;
    tick();
    reset      = 1'b0;
    load_start = 1'b0;
    chk("t7_ready", {63'h0, load_ready}, 64'h0);
    chk("t7_busy", {63'h0, busy}, 64'h0);
    chk("t7_core_reset", {63'h0, core_reset}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction memory with a streaming program-load port and a boot sequencer for the single-cycle MIPS core. It replaces the free-running write-enable/address/instruction load path. Programs are loaded through a valid/ready handshake with auto-incrementing addresses. The core is held in reset until a load completes, and the core then fetches over a combinational PC read port.

## Interface
Parameters:
- DATA_W, 32, instruction word width
- DEPTH, 64, memory depth in words; power of two, ≥ 4
- ADDR_W, 32, byte-address width of `pc` and `load_base`

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- load_start  in  1  single-cycle pulse; begins a load at `load_base`
- load_base  in  ADDR_W  byte address of the first word to load
- load_valid  in  1  `load_data` is valid
- load_data  in  DATA_W  instruction word
- load_last  in  1  qualifies the final beat of a load
- load_ready  out  1  block accepts a beat
- load_count  out  $clog2(DEPTH)+1  words accepted in the current/last load
- load_err  out  1  sticky error: misaligned base or overflow
- busy  out  1  state is LOAD or RELEASE
- core_reset  out  1  reset to the MIPS core
- pc  in  ADDR_W  core program counter (byte address)
- instruction  out  DATA_W  fetched word
- pc_fault  out  1  fetch out of range or misaligned (see Configuration)

## Operation
- States: IDLE → LOAD → RELEASE → RUN.
- A `load_start` in RUN also enters LOAD (reload).
- Reset values: state IDLE, `load_ready`=0, `load_count`=0, `load_err`=0, `busy`=0, `core_reset`=1, `instruction`=0, `pc_fault`=0. Memory contents are not cleared by reset.
- IDLE/RUN with `load_start`=1:
  - latch word pointer = `load_base[2+:$clog2(DEPTH)]`;
  - clear `load_count` and `load_err`;
  - go to LOAD.
  - If `load_base[1:0]`≠0, set `load_err` and round down.
- LOAD:
  - `load_ready`=1. A beat is accepted when `load_valid && load_ready`.
  - On an accepted beat: write `mem[ptr]`, increment ptr modulo DEPTH, increment `load_count` (saturating at DEPTH).
  - If the beat would be word DEPTH+1, it is not written and `load_err` is set. The block stays in LOAD until `load_last`.
  - An accepted beat with `load_last`=1 → RELEASE.
  - `load_start` is ignored while in LOAD.
- RELEASE: one cycle, `core_reset` still 1, then → RUN.
- RUN: `core_reset`=0. `instruction` = `mem[pc index]`, combinational.
- In IDLE, LOAD and RELEASE, `instruction`=0 (NOP) and `core_reset`=1.
- Simultaneous `reset` and `load_start`: reset wins.
- Reset mid-load: FSM returns to IDLE; words already written remain.

## Timing
- Write latency: data accepted at edge N is readable from edge N+1.
- Last beat accepted at edge N: RELEASE during cycle N→N+1, RUN and `core_reset`=0 from edge N+1 onward.
  - The core therefore sees exactly one extra reset cycle after the last write.
- `load_ready` rises the cycle after `load_start` is sampled and falls the cycle after the last beat is accepted.
- Full throughput: one beat per cycle. Gaps in `load_valid` insert idle cycles with no effect.
- `load_count` and `load_err` are registered and update the edge after the causing beat. They hold their values in RUN until the next `load_start`.
- `pc` → `instruction` and `pc` → `pc_fault` are purely combinational, with no added latency. This is required by the single-cycle core.

## Configuration
- IMEM_BOUNDS_CHECK_EN defined:
  - In RUN, if `pc` ≥ DEPTH*4 or `pc[1:0]`≠0, then `instruction`=0 and `pc_fault`=1; otherwise `pc_fault`=0.
  - Overflow detection in LOAD is active as specified.
- IMEM_BOUNDS_CHECK_EN undefined:
  - Index = `pc[2+:$clog2(DEPTH)]` (wrap, low bits ignored). `pc_fault` is tied to 0.
  - In LOAD, ptr wraps and overwrites with no overflow error. The misaligned-base error remains.

## Test plan
- Load 10 words from base 0 (0x2128000A, 0x21290002, 0x01095000, 0x01084000, 0x010A5801, 0xAD0B0004, 0x4D0C0004, 0x116C0001, 0x016C5801, 0x016C5800), `load_last` on word 10. Expect `load_count`=10, `core_reset` low one cycle after RELEASE, `pc`=8 → 0x01095000, `pc`=36 → 0x016C5800.
- Same program with `load_valid` toggled every other cycle → identical memory contents, `load_count`=10, no `load_err`.
- DEPTH=8, 9 beats with last on beat 9 (IMEM_BOUNDS_CHECK_EN) → `load_err`=1, `load_count`=8, `mem[0]` not overwritten. Without the macro → `mem[0]` holds beat 9 and `load_err`=0.
- `load_base`=0x6 → `load_err`=1, first word lands at word index 1.
- Assert `reset` after 3 of 10 beats → IDLE, `load_ready`=0, `core_reset`=1, `instruction`=0. Words 0–2 retained; a fresh load then completes normally.
- RUN with IMEM_BOUNDS_CHECK_EN, DEPTH=64: `pc`=256 → `instruction`=0, `pc_fault`=1; `pc`=0x2 → `pc_fault`=1; `pc`=4 → stored word, `pc_fault`=0.
